// File: rtl/kmeans_pkg.sv
// Shared constants and state encoding for the k-means centroid update block.
package kmeans_pkg;

  localparam int unsigned K           = 3;
  localparam int unsigned D           = 5;
  localparam int unsigned IDX_WIDTH   = 2;
  localparam int unsigned D_IDX_WIDTH = 3;
  localparam int unsigned NUM_DIV     = K * D;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kmeans_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, done pulses width cycles after start.
module kmeans_seq_divider #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] dividend,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] quotient,
  output logic             done
);

  localparam int unsigned CNT_WIDTH = $clog2(width + 1);

  logic [width-1:0]     rem_q, quo_q, div_q;
  logic [width-1:0]     src_rem, src_quo, src_div, diff_c, rem_c, quo_c;
  logic [width:0]       rem_sh_c;
  logic                 ge_c;
  logic                 active_q;
  logic [CNT_WIDTH-1:0] steps_q;

  // The start cycle performs the first step directly on the fresh operands.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_div  = start ? divisor : div_q;
    rem_sh_c = {src_rem, src_quo[width-1]};
    ge_c     = rem_sh_c >= {1'b0, src_div};
    diff_c   = rem_sh_c[width-1:0] - src_div;
    rem_c    = ge_c ? diff_c : rem_sh_c[width-1:0];
    quo_c    = {src_quo[width-2:0], ge_c};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      steps_q  <= '0;
      active_q <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_c;
        quo_q    <= quo_c;
        div_q    <= divisor;
        steps_q  <= CNT_WIDTH'(1);
        active_q <= 1'b1;
      end else if (active_q) begin
        rem_q   <= rem_c;
        quo_q   <= quo_c;
        steps_q <= steps_q + CNT_WIDTH'(1);
        if (steps_q == CNT_WIDTH'(width - 1)) begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/kmeans_centroid_update_k3_d5.sv
// Per-centroid sum/count accumulation and end-of-epoch mean computation (K=3, D=5)
// using one shared sequential divider.
module kmeans_centroid_update_k3_d5
  import kmeans_pkg::*;
#(
  parameter int unsigned input_data_width = 16,
  parameter int unsigned count_width      = 16,
  parameter int unsigned acc_width        = input_data_width + count_width
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [input_data_width-1:0] input_data0,
  input  logic [input_data_width-1:0] input_data1,
  input  logic [input_data_width-1:0] input_data2,
  input  logic [input_data_width-1:0] input_data3,
  input  logic [input_data_width-1:0] input_data4,
  input  logic [IDX_WIDTH-1:0]        selected_centroid,
  input  logic                        flush,
  output logic                        busy,
  output logic                        out_valid,
  output logic                        overflow,
  output logic [input_data_width-1:0] centroid0_d0,
  output logic [input_data_width-1:0] centroid0_d1,
  output logic [input_data_width-1:0] centroid0_d2,
  output logic [input_data_width-1:0] centroid0_d3,
  output logic [input_data_width-1:0] centroid0_d4,
  output logic [input_data_width-1:0] centroid1_d0,
  output logic [input_data_width-1:0] centroid1_d1,
  output logic [input_data_width-1:0] centroid1_d2,
  output logic [input_data_width-1:0] centroid1_d3,
  output logic [input_data_width-1:0] centroid1_d4,
  output logic [input_data_width-1:0] centroid2_d0,
  output logic [input_data_width-1:0] centroid2_d1,
  output logic [input_data_width-1:0] centroid2_d2,
  output logic [input_data_width-1:0] centroid2_d3,
  output logic [input_data_width-1:0] centroid2_d4
);

  state_t state_q, state_next;

  logic [input_data_width-1:0] data_c     [D];
  logic [acc_width-1:0]        sum_q      [K][D];
  logic [acc_width-1:0]        sum_next   [K][D];
  logic [count_width-1:0]      count_q    [K];
  logic [count_width-1:0]      count_next [K];
  logic [input_data_width-1:0] centroid_q [K][D];
  logic                        overflow_next;

  logic [IDX_WIDTH-1:0]   k_q, k_adv, op_k;
  logic [D_IDX_WIDTH-1:0] d_q, d_adv, op_d;
  logic                   last_c;
  logic                   div_start_c, div_done;
  logic [acc_width-1:0]   div_dividend, div_divisor, div_quotient;
  logic                   unused_quot_hi;

  assign data_c[0] = input_data0;
  assign data_c[1] = input_data1;
  assign data_c[2] = input_data2;
  assign data_c[3] = input_data3;
  assign data_c[4] = input_data4;

  // Next-state controller
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_ACC:  if (flush) state_next = ST_DIV;
      ST_DIV:  if (div_done && last_c) state_next = ST_DIV == state_q ? ST_DONE : state_q;
      ST_DONE: state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_next;
      in_ready  <= state_next == ST_ACC;
      busy      <= state_next != ST_ACC;
      out_valid <= state_next == ST_DONE;
    end
  end

  // Accumulation; saturated counters drop the sample and flag overflow.
  always_comb begin
    overflow_next = overflow;
    for (int k = 0; k < K; k++) begin
      count_next[k] = count_q[k];
      for (int d = 0; d < D; d++) sum_next[k][d] = sum_q[k][d];
    end
    if (state_q == ST_DONE) begin
      overflow_next = 1'b0;
      for (int k = 0; k < K; k++) begin
        count_next[k] = '0;
        for (int d = 0; d < D; d++) sum_next[k][d] = '0;
      end
    end else if (state_q == ST_ACC && in_valid) begin
      for (int k = 0; k < K; k++) begin
        if (selected_centroid == IDX_WIDTH'(k)) begin
          if (count_q[k] == '1) begin
            overflow_next = 1'b1;
          end else begin
            count_next[k] = count_q[k] + count_width'(1);
            for (int d = 0; d < D; d++)
              sum_next[k][d] = sum_q[k][d] + acc_width'(data_c[d]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      for (int k = 0; k < K; k++) begin
        count_q[k] <= '0;
        for (int d = 0; d < D; d++) sum_q[k][d] <= '0;
      end
    end else begin
      overflow <= overflow_next;
      for (int k = 0; k < K; k++) begin
        count_q[k] <= count_next[k];
        for (int d = 0; d < D; d++) sum_q[k][d] <= sum_next[k][d];
      end
    end
  end

  // Division sequencing; operands come from the next-state sums so a sample
  // arriving with flush is included in the very first division.
  always_comb begin
    last_c = (k_q == IDX_WIDTH'(K - 1)) && (d_q == D_IDX_WIDTH'(D - 1));
    if (d_q == D_IDX_WIDTH'(D - 1)) begin
      d_adv = '0;
      k_adv = k_q + IDX_WIDTH'(1);
    end else begin
      d_adv = d_q + D_IDX_WIDTH'(1);
      k_adv = k_q;
    end
    op_k         = (state_q == ST_ACC || last_c) ? '0 : k_adv;
    op_d         = (state_q == ST_ACC || last_c) ? '0 : d_adv;
    div_dividend = sum_next[op_k][op_d];
    div_divisor  = acc_width'(count_next[op_k]);
    div_start_c  = (state_q == ST_ACC && flush) ||
                   (state_q == ST_DIV && div_done && !last_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      d_q <= '0;
      for (int k = 0; k < K; k++)
        for (int d = 0; d < D; d++) centroid_q[k][d] <= '0;
    end else if (state_q == ST_DIV && div_done) begin
      if (count_q[k_q] != '0)
        centroid_q[k_q][d_q] <= div_quotient[input_data_width-1:0];
      k_q <= op_k;
      d_q <= op_d;
    end
  end

  assign unused_quot_hi = ^div_quotient[acc_width-1:input_data_width];

  kmeans_seq_divider #(
    .width (acc_width)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  assign centroid0_d0 = centroid_q[0][0];
  assign centroid0_d1 = centroid_q[0][1];
  assign centroid0_d2 = centroid_q[0][2];
  assign centroid0_d3 = centroid_q[0][3];
  assign centroid0_d4 = centroid_q[0][4];
  assign centroid1_d0 = centroid_q[1][0];
  assign centroid1_d1 = centroid_q[1][1];
  assign centroid1_d2 = centroid_q[1][2];
  assign centroid1_d3 = centroid_q[1][3];
  assign centroid1_d4 = centroid_q[1][4];
  assign centroid2_d0 = centroid_q[2][0];
  assign centroid2_d1 = centroid_q[2][1];
  assign centroid2_d2 = centroid_q[2][2];
  assign centroid2_d3 = centroid_q[2][3];
  assign centroid2_d4 = centroid_q[2][4];

endmodule

// File: tb/tb_kmeans_centroid_update_k3_d5.sv
// Directed bench for the centroid update block: default build plus a 4-bit-count build for saturation.
module tb_kmeans_centroid_update_k3_d5;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, flush, tgt;
  logic [1:0]    sel;
  logic [DW-1:0] din [5];
  logic          in_valid_m, in_valid_s, flush_m, flush_s;

  assign in_valid_m = in_valid & ~tgt;
  assign in_valid_s = in_valid & tgt;
  assign flush_m    = flush & ~tgt;
  assign flush_s    = flush & tgt;

  logic          in_ready, busy, out_valid, overflow;
  logic          in_ready_s, busy_s, out_valid_s, overflow_s;
  logic [DW-1:0] c  [3][5];
  logic [DW-1:0] cs [3][5];

  int n_checks = 0;
  int n_fail   = 0;

  kmeans_centroid_update_k3_d5 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready),
    .input_data0(din[0]), .input_data1(din[1]), .input_data2(din[2]),
    .input_data3(din[3]), .input_data4(din[4]),
    .selected_centroid(sel), .flush(flush_m), .busy(busy),
    .out_valid(out_valid), .overflow(overflow),
    .centroid0_d0(c[0][0]), .centroid0_d1(c[0][1]), .centroid0_d2(c[0][2]),
    .centroid0_d3(c[0][3]), .centroid0_d4(c[0][4]),
    .centroid1_d0(c[1][0]), .centroid1_d1(c[1][1]), .centroid1_d2(c[1][2]),
    .centroid1_d3(c[1][3]), .centroid1_d4(c[1][4]),
    .centroid2_d0(c[2][0]), .centroid2_d1(c[2][1]), .centroid2_d2(c[2][2]),
    .centroid2_d3(c[2][3]), .centroid2_d4(c[2][4])
  );

  kmeans_centroid_update_k3_d5 #(.count_width(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .input_data0(din[0]), .input_data1(din[1]), .input_data2(din[2]),
    .input_data3(din[3]), .input_data4(din[4]),
    .selected_centroid(sel), .flush(flush_s), .busy(busy_s),
    .out_valid(out_valid_s), .overflow(overflow_s),
    .centroid0_d0(cs[0][0]), .centroid0_d1(cs[0][1]), .centroid0_d2(cs[0][2]),
    .centroid0_d3(cs[0][3]), .centroid0_d4(cs[0][4]),
    .centroid1_d0(cs[1][0]), .centroid1_d1(cs[1][1]), .centroid1_d2(cs[1][2]),
    .centroid1_d3(cs[1][3]), .centroid1_d4(cs[1][4]),
    .centroid2_d0(cs[2][0]), .centroid2_d1(cs[2][1]), .centroid2_d2(cs[2][2]),
    .centroid2_d3(cs[2][3]), .centroid2_d4(cs[2][4])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_sample(input int s, input int v0, input int v1, input int v2,
                            input int v3, input int v4);
    sel      = 2'(s);
    din[0]   = DW'(v0);
    din[1]   = DW'(v1);
    din[2]   = DW'(v2);
    din[3]   = DW'(v3);
    din[4]   = DW'(v4);
    in_valid = 1'b1;
  endtask

  task automatic send(input int s, input int v0, input int v1, input int v2,
                      input int v3, input int v4);
    set_sample(s, v0, v1, v2, v3, v4);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_c(input string tag, input int k, input int e0, input int e1,
                         input int e2, input int e3, input int e4, input bit sat);
    int e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int d = 0; d < 5; d++)
      check($sformatf("%s_c%0d_d%0d", tag, k, d), sat ? 32'(cs[k][d]) : 32'(c[k][d]), 32'(e[d]));
  endtask

  // Flush (with whatever sample is already on the inputs), then wait for out_valid.
  task automatic run_epoch(input string tag, input bit dirty, input bit sat, input int exp_cycles);
    int n;
    bit busy_ok, ready_ok, b, ov, r;
    flush = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n = 1; busy_ok = 1'b1; ready_ok = 1'b1;
    while (n < 2000) begin
      if (dirty) set_sample(0, 999, 999, 999, 999, 999);
      b  = sat ? busy_s : busy;
      ov = sat ? out_valid_s : out_valid;
      r  = sat ? in_ready_s : in_ready;
      if (!b) busy_ok = 1'b0;
      if (r) ready_ok = 1'b0;
      if (ov) break;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    if (dirty) check({tag, "_ready_low"}, 32'(ready_ok), 32'd1);
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, 32'(sat ? out_valid_s : out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(sat ? in_ready_s : in_ready), 32'd1);
    check({tag, "_busy_off"}, 32'(sat ? busy_s : busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    tgt = 1'b0; in_valid = 1'b0; flush = 1'b0; sel = '0;
    for (int d = 0; d < 5; d++) din[d] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_c0d0", 32'(c[0][0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic means
    send(0, 10, 20, 30, 40, 50);
    send(0, 20, 30, 40, 50, 60);
    send(1, 7, 7, 7, 7, 7);
    run_epoch("basic", 1'b0, 1'b0, 481);
    check_c("basic", 0, 15, 25, 35, 45, 55, 1'b0);
    check_c("basic", 1, 7, 7, 7, 7, 7, 1'b0);
    check_c("basic", 2, 0, 0, 0, 0, 0, 1'b0);

    // Truncation
    send(1, 1, 0, 0, 0, 65535);
    send(1, 2, 1, 0, 0, 65534);
    run_epoch("trunc", 1'b0, 1'b0, 481);
    check_c("trunc", 1, 1, 0, 0, 0, 65534, 1'b0);
    check_c("trunc", 0, 15, 25, 35, 45, 55, 1'b0);

    // Dropped index 3, flush coincident with a sample, samples offered during DIV
    send(3, 100, 100, 100, 100, 100);
    send(3, 200, 200, 200, 200, 200);
    set_sample(2, 4, 4, 4, 4, 4);
    run_epoch("same", 1'b1, 1'b0, 481);
    check_c("same", 2, 4, 4, 4, 4, 4, 1'b0);
    check_c("same", 0, 15, 25, 35, 45, 55, 1'b0);
    check_c("same", 1, 1, 0, 0, 0, 65534, 1'b0);

    // Back-to-back empty epoch
    run_epoch("b2b", 1'b0, 1'b0, 481);
    check_c("b2b", 0, 15, 25, 35, 45, 55, 1'b0);
    check_c("b2b", 1, 1, 0, 0, 0, 65534, 1'b0);
    check_c("b2b", 2, 4, 4, 4, 4, 4, 1'b0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("b2b_no_extra_pulse", 32'(pulses), 32'd0);

    // Reset mid-division
    send(0, 1, 1, 1, 1, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_c0d0", 32'(c[0][0]), 32'd0);
    check("midrst_c1d4", 32'(c[1][4]), 32'd0);
    check("midrst_c2d0", 32'(c[2][0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 9, 8, 7, 6, 5);
    run_epoch("postrst", 1'b0, 1'b0, 481);
    check_c("postrst", 0, 9, 8, 7, 6, 5, 1'b0);
    check_c("postrst", 1, 0, 0, 0, 0, 0, 1'b0);

    // Saturation on the 4-bit-count build
    tgt = 1'b1;
    repeat (16) send(0, 3, 3, 3, 3, 3);
    check("sat_overflow_set", 32'(overflow_s), 32'd1);
    check("sat_main_untouched", 32'(overflow), 32'd0);
    run_epoch("sat", 1'b0, 1'b1, 301);
    check_c("sat", 0, 3, 3, 3, 3, 3, 1'b1);
    check_c("sat", 1, 0, 0, 0, 0, 0, 1'b1);
    check("sat_overflow_clear", 32'(overflow_s), 32'd0);
    tgt = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kmeans_centroid_update_k3_d5.md
Name: kmeans_centroid_update_k3_d5

Overview:
Consumer end of the k-means assignment pipeline (K=3 centroids, D=5 dimensions). Takes each assigned sample, meaning the delayed data plus its selected centroid index, and accumulates per-centroid, per-dimension sums and per-centroid counts. On an end-of-epoch flush it divides every sum by its count with one shared sequential divider and presents the new centroids, which feed back to the assignment pipeline's centroid inputs.

Parameters:
input_data_width, 16, width of each data/centroid dimension (unsigned)
count_width, 16, width of each per-centroid sample counter
acc_width, input_data_width+count_width, width of each sum accumulator and of the divider

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  sample present on input_data*/selected_centroid this cycle
in_ready  output  1  block accepts samples (high only in ACC state)
input_data0..input_data4  input  input_data_width each  sample dimensions
selected_centroid  input  2  assigned centroid index 0..2
flush  input  1  single-cycle pulse: end of epoch, start centroid recompute
busy  output  1  high in DIV and DONE states
out_valid  output  1  one-cycle pulse: all centroid outputs hold the new values
overflow  output  1  sticky: at least one sample dropped this epoch because its count saturated
centroidK_dD (K=0..2, D=0..4)  output  input_data_width each  current centroid registers (15 ports)

Behaviour:
- Reset (asynchronous, any state, including mid-division): state=ACC; all sums, counts, centroid registers, overflow, out_valid and divider state go to 0; in_ready=1; busy=0.
- States: ACC -> DIV on flush. DIV -> DONE when the 15th division completes. DONE -> ACC after exactly 1 cycle.
- ACC, accepting a sample: in_valid=1 and selected_centroid in 0..2. Add input_dataD, zero-extended, to sum[sel][D]; count[sel]+1.
- ACC, dropped samples: selected_centroid=3 is dropped silently with no state change. A sample whose count[sel] equals 2^count_width-1 is also dropped, and overflow is set to 1.
- A sum cannot wrap while its count is unsaturated, given acc_width.
- flush and in_valid in the same ACC cycle: the sample is accumulated first, then the block enters DIV.
- flush outside ACC is ignored.
- in_valid outside ACC is ignored (in_ready=0).
- DIV order: K0D0, K0D1 … K0D4, K1D0 … K2D4.
- Each division is unsigned restoring division, 1 quotient bit per cycle, exactly acc_width cycles; there are no gaps between divisions.
- Quotient = floor(sum/count), truncated to input_data_width. It always fits, because a mean never exceeds the max sample.
- The centroid register is written on the cycle its division completes.
- count=0: the division still consumes acc_width cycles, but the centroid register is not written (it retains its previous value).
- Timing: flush sampled at edge T; DIV occupies edges T+1 … T+15*acc_width; DONE at edge T+15*acc_width+1, with out_valid=1 for that single cycle (481 cycles after flush at defaults).
- On the DONE cycle all sums, counts and overflow clear to 0 simultaneously.
- Centroid outputs are only guaranteed mutually consistent when busy=0.

Decomposition:
- Shared package kmeans_pkg:
  - K=3, D=5
  - IDX_WIDTH=2
  - state encoding (ACC, DIV, DONE)
  - K*D division count constant
- One sub-module: kmeans_seq_divider.
  - Parameter: width.
  - Ports: clk, rst, start, dividend, divisor, quotient, done.
  - done is a 1-cycle pulse exactly width cycles after start.
  - Behaviour for divisor=0 is don't-care, because the parent skips the write.

Test Plan:
- Basic means:
  - Stimulus: c0 gets (10,20,30,40,50) and (20,30,40,50,60); c1 gets (7,7,7,7,7); c2 gets nothing; then flush.
  - Required: out_valid 481 cycles after flush; c0=(15,25,35,45,55); c1=(7,7,7,7,7); c2=(0,0,0,0,0) retained; busy high throughout.
- Truncation:
  - Stimulus: c1 gets (1,0,0,0,65535) and (2,1,0,0,65534); then flush.
  - Required: c1=(1,0,0,0,65534).
- Same-cycle and ignored inputs:
  - Stimulus: flush coincident with in_valid sample (4,4,4,4,4) to c2, the only c2 sample; samples offered during DIV; selected_centroid=3 samples during ACC.
  - Required: c2=(4,4,4,4,4); in_ready=0 during DIV; the other samples have no effect.
- Saturation:
  - Stimulus: count_width=4 build; 16 samples of value 3 to c0.
  - Required: 15 accepted; overflow=1 before flush; c0=(3,3,3,3,3); overflow=0 after DONE.
- Reset mid-DIV:
  - Stimulus: assert rst 100 cycles after flush.
  - Required: all outputs 0 immediately; in_ready=1; a subsequent epoch of one sample (9,8,7,6,5) to c0 yields c0=(9,8,7,6,5).
- Back-to-back epochs:
  - Stimulus: second epoch with no samples.
  - Required: centroids unchanged from the first epoch; out_valid pulses exactly once per flush.
